bus_slave_port: RTL

Slave-side endpoint of the serial system bus. It sits behind one arbiter slave output (`sN_address`, `sN_data`, `sN_valid`, `sN_ready`) and deserialises each write frame, address bits first and then data bits. It commits each completed frame into a local word memory. A registered local read port lets the owning peripheral and the test bench inspect memory contents.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_slave_mem.sv | 34 +++
 rtl/bus_slave_port.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: frame geometry defaults and
// the slave endpoint state encoding.
package bus_pkg;

  localparam int BUS_ADDR_W = 12;
  localparam int BUS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE
  } slave_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_slave_mem.sv
// DEPTH x DATA_W word memory with one write port and one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module bus_slave_mem #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bus_slave_port.sv
// Slave endpoint of the serial system bus: deserialises address-then-data write
// frames (MSB first) and commits each complete frame into a local word memory.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int DEPTH  = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_address,
  input  logic                     s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     wr_done,
  output logic                     addr_err,
  output logic                     abort,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(max_int(ADDR_W, DATA_W)) + 1;
  localparam int LIM_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(DEPTH);

  slave_state_t      state;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [CNT_W-1:0]  cnt;
  logic              addr_ok;

  // One extra bit so that DEPTH == 2**ADDR_W compares correctly.
  assign addr_ok = {1'b0, addr_sr} < DEPTH_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      wr_done  <= 1'b0;
      addr_err <= 1'b0;
      abort    <= 1'b0;
      addr_sr  <= '0;
      data_sr  <= '0;
      cnt      <= '0;
    end else begin
      wr_done  <= 1'b0;
      addr_err <= 1'b0;
      abort    <= 1'b0;
      s_ready  <= 1'b1;
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            addr_sr <= {addr_sr[ADDR_W-2:0], s_address};
            cnt     <= CNT_W'(1);
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (!s_valid) begin
            abort <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            addr_sr <= {addr_sr[ADDR_W-2:0], s_address};
            if (cnt == ADDR_LAST) begin
              cnt   <= '0;
              state <= DATA;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (!s_valid) begin
            abort <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            data_sr <= {data_sr[DATA_W-2:0], s_data};
            if (cnt == DATA_LAST) begin
              // Outcome pulses and the stall are registered so they line up
              // exactly with the WRITE cycle.
              cnt      <= '0;
              state    <= WRITE;
              s_ready  <= 1'b0;
              wr_done  <= addr_ok;
              addr_err <= !addr_ok;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  // wr_done is high only in a WRITE cycle with an in-range address.
  bus_slave_mem #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (wr_done),
    .waddr(addr_sr[MEM_AW-1:0]),
    .wdata(data_sr),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule
